// File: rtl/mips_pkg.sv
// Shared constants and types for the Harvard MIPS instruction-fetch path.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR    = 32'h0;
    localparam logic [31:0] NOP_WORD     = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_rom_responder_rom_array.sv
// Word array with a registered read port and an independent preload write port.
module rom_array #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_index,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_index,
  input  logic [31:0]           wr_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
  end

  // Read samples the pre-write contents when both ports hit the same word.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_index];
    end
  end

endmodule

// File: rtl/instr_rom_responder.sv
// Instruction-memory responder: read/waitrequest handshake in front of a preloadable ROM.
module instr_rom_responder
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic [31:0]           address,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    output logic                  addr_error,
    output logic                  proto_error,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_index,
    input  logic [31:0]           load_data
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    fetch_state_t          state;
    logic [3:0]            wait_count;
    logic [31:0]           captured_address;
    logic [31:0]           decode_address;
    logic [32:0]           offset;
    logic [ADDR_WIDTH-1:0] word_index;
    logic                  is_halt;
    logic                  misaligned;
    logic                  below_base;
    logic                  beyond_top;
    logic                  decode_error;
    logic                  enter_resp;
    logic                  resp_data_valid;
    logic                  resp_halt;
    logic                  resp_error;
    logic                  proto_error_q;
    logic [31:0]           rom_word;
    logic                  unused_offset_bits;

    // A zero-wait fetch registers its response on the capture edge, so decode the live address then.
    assign decode_address = (state == ST_IDLE) ? address : captured_address;

    // 33-bit subtract: bit 32 is the borrow (below base); any set bit above the
    // array span means at or past BASE_ADDR + 4*2^ADDR_WIDTH without wrapping.
    always_comb begin
        offset       = {1'b0, decode_address} - {1'b0, BASE_ADDR};
        word_index   = offset[ADDR_WIDTH+1:2];
        is_halt      = (decode_address == HALT_ADDR);
        misaligned   = |decode_address[1:0];
        below_base   = offset[32];
        beyond_top   = |offset[31:ADDR_WIDTH+2];
        decode_error = !is_halt && (misaligned || below_base || beyond_top);
    end

    assign unused_offset_bits = ^offset[1:0];

    always_comb begin
        enter_resp = 1'b0;
        if (read) begin
            if (state == ST_IDLE && WAIT_CYCLES == 0) begin
                enter_resp = 1'b1;
            end else if (state == ST_WAIT && wait_count == 4'd1) begin
                enter_resp = 1'b1;
            end
        end
    end

    rom_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_rom (
        .clk      (clk),
        .rd_en    (enter_resp),
        .rd_index (word_index),
        .rd_data  (rom_word),
        .wr_en    (load_en),
        .wr_index (load_index),
        .wr_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            wait_count       <= '0;
            captured_address <= '0;
            resp_data_valid  <= 1'b0;
            resp_halt        <= 1'b0;
            resp_error       <= 1'b0;
            proto_error_q    <= 1'b0;
        end else begin
            if (enter_resp) begin
                resp_error      <= decode_error;
                resp_halt       <= is_halt;
                resp_data_valid <= !is_halt && !decode_error;
            end

            case (state)
                ST_IDLE: begin
                    if (read) begin
                        captured_address <= address;
                        wait_count       <= WAIT_INIT;
                        state            <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!read) begin
                        state <= ST_IDLE;
                    end else begin
                        if (address != captured_address) begin
                            proto_error_q <= 1'b1;
                        end
                        if (wait_count == 4'd1) begin
                            state <= ST_RESP;
                        end else begin
                            wait_count <= wait_count - 4'd1;
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign waitrequest = read && (state != ST_RESP);
    assign readdata    = resp_data_valid ? rom_word : (resp_halt ? NOP_WORD : '0);
    assign addr_error  = resp_error;
    assign proto_error = proto_error_q;

endmodule

// File: tb/tb_instr_rom_responder.sv
// Directed bench for instr_rom_responder with a one-wait-state and a zero-wait-state instance.
module tb_instr_rom_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        read;
    logic [31:0] address;
    logic        read0;
    logic [31:0] address0;
    logic        load_en;
    logic [9:0]  load_index;
    logic [31:0] load_data;

    logic        waitrequest;
    logic [31:0] readdata;
    logic        addr_error;
    logic        proto_error;
    logic        waitrequest0;
    logic [31:0] readdata0;
    logic        addr_error0;
    logic        proto_error0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_rom_responder #(
        .ADDR_WIDTH  (10),
        .BASE_ADDR   (32'hBFC00000),
        .WAIT_CYCLES (1),
        .INIT_FILE   ("")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .read        (read),
        .address     (address),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .addr_error  (addr_error),
        .proto_error (proto_error),
        .load_en     (load_en),
        .load_index  (load_index),
        .load_data   (load_data)
    );

    instr_rom_responder #(
        .ADDR_WIDTH  (10),
        .BASE_ADDR   (32'hBFC00000),
        .WAIT_CYCLES (0),
        .INIT_FILE   ("")
    ) dut0 (
        .clk         (clk),
        .reset       (reset),
        .read        (read0),
        .address     (address0),
        .waitrequest (waitrequest0),
        .readdata    (readdata0),
        .addr_error  (addr_error0),
        .proto_error (proto_error0),
        .load_en     (load_en),
        .load_index  (load_index),
        .load_data   (load_data)
    );

    task automatic preload(input logic [9:0] idx, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_index = idx; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // One-wait-state fetch: waitrequest high in cycles 0 and 1, response in cycle 2.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_d,
                            input logic exp_e, input string nm);
        @(negedge clk);
        read = 1'b1; address = a; #1;
        tests++;
        if (waitrequest !== 1'b1) begin
            fails++; $display("FAIL %s wait_c0: got %b want 1", nm, waitrequest);
        end
        @(negedge clk); #1;
        tests++;
        if (waitrequest !== 1'b1) begin
            fails++; $display("FAIL %s wait_c1: got %b want 1", nm, waitrequest);
        end
        @(negedge clk); #1;
        tests++;
        if (waitrequest !== 1'b0) begin
            fails++; $display("FAIL %s wait_resp: got %b want 0", nm, waitrequest);
        end
        tests++;
        if (readdata !== exp_d) begin
            fails++; $display("FAIL %s readdata: got %h want %h", nm, readdata, exp_d);
        end
        tests++;
        if (addr_error !== exp_e) begin
            fails++; $display("FAIL %s addr_error: got %b want %b", nm, addr_error, exp_e);
        end
        read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; read = 1'b0; read0 = 1'b0; address = '0; address0 = '0;
        load_en = 1'b0; load_index = '0; load_data = '0;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (waitrequest !== 1'b0) begin fails++; $display("FAIL rst_wait: got %b want 0", waitrequest); end
        tests++;
        if (readdata !== 32'h0) begin fails++; $display("FAIL rst_readdata: got %h want 0", readdata); end
        tests++;
        if (addr_error !== 1'b0) begin fails++; $display("FAIL rst_addr_error: got %b want 0", addr_error); end
        tests++;
        if (proto_error !== 1'b0) begin fails++; $display("FAIL rst_proto: got %b want 0", proto_error); end
        tests++;
        if (readdata0 !== 32'h0) begin fails++; $display("FAIL rst_readdata0: got %h want 0", readdata0); end
        tests++;
        if (proto_error0 !== 1'b0) begin fails++; $display("FAIL rst_proto0: got %b want 0", proto_error0); end
        reset = 1'b0;
    endtask

    task automatic test_preload_fetch();
        preload(10'd0, 32'h24020005);
        preload(10'd1, 32'h00000008);
        preload(10'd1023, 32'hDEADBEEF);
        do_fetch(32'hBFC00000, 32'h24020005, 1'b0, "fetch_w0");
        do_fetch(32'hBFC00004, 32'h00000008, 1'b0, "fetch_w1");
    endtask

    task automatic test_decode();
        do_fetch(32'h00000000, 32'h0, 1'b0, "halt");
        do_fetch(32'hBFC00002, 32'h0, 1'b1, "misaligned");
        do_fetch(32'hBFC01000, 32'h0, 1'b1, "past_end");
        do_fetch(32'hBFBFFFFC, 32'h0, 1'b1, "below_base");
        do_fetch(32'hBFC00FFC, 32'hDEADBEEF, 1'b0, "last_word");
    endtask

    task automatic test_zero_wait();
        @(negedge clk);
        read0 = 1'b1; address0 = 32'hBFC00000; #1;
        tests++;
        if (waitrequest0 !== 1'b1) begin fails++; $display("FAIL zw_wait_c0: got %b want 1", waitrequest0); end
        @(negedge clk); #1;
        tests++;
        if (waitrequest0 !== 1'b0) begin fails++; $display("FAIL zw_wait_resp: got %b want 0", waitrequest0); end
        tests++;
        if (readdata0 !== 32'h24020005) begin fails++; $display("FAIL zw_readdata: got %h want 24020005", readdata0); end
        tests++;
        if (addr_error0 !== 1'b0) begin fails++; $display("FAIL zw_addr_error: got %b want 0", addr_error0); end
        read0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        read0 = 1'b1; address0 = 32'hBFC00004; #1;
        tests++;
        if (waitrequest0 !== 1'b1) begin fails++; $display("FAIL b2b_wait_a: got %b want 1", waitrequest0); end
        @(negedge clk); #1;
        tests++;
        if (waitrequest0 !== 1'b0 || readdata0 !== 32'h00000008) begin
            fails++; $display("FAIL b2b_resp_a: got wr=%b data=%h want wr=0 data=00000008", waitrequest0, readdata0);
        end
        address0 = 32'hBFC00000;
        @(negedge clk); #1;
        tests++;
        if (waitrequest0 !== 1'b1) begin fails++; $display("FAIL b2b_dead_cycle: got %b want 1", waitrequest0); end
        @(negedge clk); #1;
        tests++;
        if (waitrequest0 !== 1'b0 || readdata0 !== 32'h24020005) begin
            fails++; $display("FAIL b2b_resp_b: got wr=%b data=%h want wr=0 data=24020005", waitrequest0, readdata0);
        end
        read0 = 1'b0;
    endtask

    task automatic test_proto();
        @(negedge clk);
        read = 1'b1; address = 32'hBFC00000;
        @(negedge clk);
        address = 32'hBFC00004; #1;
        tests++;
        if (proto_error !== 1'b0) begin fails++; $display("FAIL proto_early: got %b want 0", proto_error); end
        @(negedge clk); #1;
        tests++;
        if (waitrequest !== 1'b0) begin fails++; $display("FAIL proto_wait: got %b want 0", waitrequest); end
        tests++;
        if (readdata !== 32'h24020005) begin fails++; $display("FAIL proto_readdata: got %h want 24020005", readdata); end
        tests++;
        if (proto_error !== 1'b1) begin fails++; $display("FAIL proto_set: got %b want 1", proto_error); end
        read = 1'b0; address = '0;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (proto_error !== 1'b1) begin fails++; $display("FAIL proto_sticky: got %b want 1", proto_error); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        read = 1'b1; address = 32'hBFC00000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; #1;
        tests++;
        if (waitrequest !== 1'b1) begin fails++; $display("FAIL rmid_wait_idle: got %b want 1", waitrequest); end
        tests++;
        if (proto_error !== 1'b0) begin fails++; $display("FAIL rmid_proto: got %b want 0", proto_error); end
        tests++;
        if (readdata !== 32'h0) begin fails++; $display("FAIL rmid_readdata: got %h want 0", readdata); end
        @(negedge clk); #1;
        tests++;
        if (waitrequest !== 1'b1) begin fails++; $display("FAIL rmid_wait_c1: got %b want 1", waitrequest); end
        @(negedge clk); #1;
        tests++;
        if (waitrequest !== 1'b0 || readdata !== 32'h24020005) begin
            fails++; $display("FAIL rmid_resp: got wr=%b data=%h want wr=0 data=24020005", waitrequest, readdata);
        end
        tests++;
        if (addr_error !== 1'b0) begin fails++; $display("FAIL rmid_addr_error: got %b want 0", addr_error); end
        read = 1'b0;
    endtask

    task automatic test_drop_read();
        @(negedge clk);
        read = 1'b1; address = 32'hBFC00000;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        read = 1'b1; address = 32'hBFC00004; #1;
        tests++;
        if (waitrequest !== 1'b1) begin fails++; $display("FAIL drop_no_resp: got %b want 1", waitrequest); end
        @(negedge clk); #1;
        tests++;
        if (waitrequest !== 1'b1) begin fails++; $display("FAIL drop_wait_c1: got %b want 1", waitrequest); end
        @(negedge clk); #1;
        tests++;
        if (waitrequest !== 1'b0) begin fails++; $display("FAIL drop_wait_resp: got %b want 0", waitrequest); end
        tests++;
        if (readdata !== 32'h00000008) begin fails++; $display("FAIL drop_readdata: got %h want 00000008", readdata); end
        tests++;
        if (addr_error !== 1'b0) begin fails++; $display("FAIL drop_addr_error: got %b want 0", addr_error); end
        read = 1'b0;
    endtask

    task automatic test_preload_collision();
        @(negedge clk);
        read = 1'b1; address = 32'hBFC00004;
        @(negedge clk);
        load_en = 1'b1; load_index = 10'd1; load_data = 32'h11223344;
        @(negedge clk);
        load_en = 1'b0; #1;
        tests++;
        if (waitrequest !== 1'b0) begin fails++; $display("FAIL collide_wait: got %b want 0", waitrequest); end
        tests++;
        if (readdata !== 32'h00000008) begin fails++; $display("FAIL collide_old: got %h want 00000008", readdata); end
        read = 1'b0;
        do_fetch(32'hBFC00004, 32'h11223344, 1'b0, "collide_new");
    endtask

    initial begin
        test_reset();
        test_preload_fetch();
        test_decode();
        test_zero_wait();
        test_back_to_back();
        test_proto();
        test_reset_mid();
        test_drop_read();
        test_preload_collision();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
